// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg: shared types and constants for the program sequencer.
//   seq_state_t : sequencer FSM states
//   NUM_PROGS   : number of program slots, IDX_W : program index width
//   PROG_PC     : start PC of each program
//   prog_pc()   : bounded lookup into PROG_PC
//   next_prog() : lowest set mask bit at or above a start index ({found, index})
//   any_prog()  : found flag of next_prog()
package prog_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_HOLD,
    S_RUN,
    S_DONE
  } seq_state_t;

  localparam int NUM_PROGS = 3;
  localparam int IDX_W     = 2;

  localparam logic [9:0] PROG_PC [NUM_PROGS] = '{10'd0, 10'd64, 10'd128};

  // Index 3 is the "past the last program" search position; it maps to PC 0.
  function automatic logic [9:0] prog_pc(input logic [IDX_W-1:0] i);
    return (int'(i) < NUM_PROGS) ? PROG_PC[i] : 10'd0;
  endfunction

  // Scan from the top down so the last hit is the lowest qualifying bit.
  function automatic logic [IDX_W:0] next_prog(input logic [NUM_PROGS-1:0] mask,
                                               input logic [IDX_W-1:0]     from);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_PROGS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) res = {1'b1, IDX_W'(i)};
    end
    return res;
  endfunction

  function automatic logic any_prog(input logic [NUM_PROGS-1:0] mask,
                                    input logic [IDX_W-1:0]     from);
    logic [IDX_W:0] r;
    r = next_prog(mask, from);
    return r[IDX_W];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk_i  : clock           rst_i : synchronous reset to 0
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count enable
//   q_o    : current count    nxt_o : value the counter takes at the next edge
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (en_i && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q_o   = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs the benchmark programs selected by prog_mask on the
// core one after another, holding the core in init with the program's start
// PC, releasing it, and recording the RUN-cycle count when core_done arrives.
//
// Optional feature macro: PROG_SEQ_TIMEOUT_EN (watchdog, timeout_err port,
// TIMEOUT_CYCLES parameter). Without it RUN waits indefinitely.
//
// Ports:
//   clk, init (sync active-high reset), start, prog_mask  : control inputs
//   core_done                                           : core completion level
//   core_init, core_start_pc                            : core control
//   busy, prog_idx, all_done                            : status
//   cyc_sel -> cyc_count                                : count readback (comb)
//   timeout_err                                         : watchdog (optional)
//
// Handshake: start is a one-cycle request accepted only in IDLE/DONE; it is
// dropped without effect while busy. core_done is a level sampled every RUN
// cycle except the first.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int CNT_W       = 16,
  parameter int INIT_CYCLES = 2
`ifdef PROG_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 60000
`endif
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic                 start,
  input  logic [NUM_PROGS-1:0] prog_mask,
  input  logic                 core_done,
  output logic                 core_init,
  output logic [PC_W-1:0]      core_start_pc,
  output logic                 busy,
  output logic [IDX_W-1:0]     prog_idx,
  output logic                 all_done,
  input  logic [IDX_W-1:0]     cyc_sel,
  output logic [CNT_W-1:0]     cyc_count
`ifdef PROG_SEQ_TIMEOUT_EN
  , output logic               timeout_err
`endif
);

  localparam int HOLD_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES + 1) : 1;

  seq_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;      // current / last program
  logic [IDX_W-1:0]     srch_q, srch_d;    // where the next PICK starts searching
  logic [NUM_PROGS-1:0] mask_q, mask_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0]     cyc_q [NUM_PROGS];
  logic [CNT_W-1:0]     cyc_d [NUM_PROGS];
  logic [CNT_W-1:0]     run_q, run_nxt;
  logic [IDX_W:0]       pick;
  logic                 pend_d;
  logic                 core_init_q, busy_q, all_done_q;
  logic [PC_W-1:0]      pc_q;
`ifdef PROG_SEQ_TIMEOUT_EN
  logic                 tmo_q, tmo_d;
`endif

  // Run counter: held at 0 outside RUN, so run_q==0 marks the first RUN cycle
  // and run_nxt is the count including the current cycle.
  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk_i (clk),
    .rst_i (init),
    .clr_i (state_q != S_RUN),
    .en_i  (state_q == S_RUN),
    .q_o   (run_q),
    .nxt_o (run_nxt)
  );

  assign pick = next_prog(mask_q, srch_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    srch_d  = srch_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
`ifdef PROG_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mask_d = prog_mask;
          idx_d  = '0;
          srch_d = '0;
          for (int i = 0; i < NUM_PROGS; i++) cyc_d[i] = '0;
`ifdef PROG_SEQ_TIMEOUT_EN
          tmo_d  = 1'b0;
`endif
          state_d = S_PICK;
        end
      end
      S_PICK: begin
        if (pick[IDX_W]) begin
          idx_d   = pick[IDX_W-1:0];
          hold_d  = HOLD_W'(INIT_CYCLES);
          state_d = S_HOLD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_HOLD: begin
        if (hold_q <= HOLD_W'(1)) state_d = S_RUN;
        else                      hold_d  = hold_q - 1'b1;
      end
      S_RUN: begin
        // A done left high from the previous program is masked in RUN cycle 1.
        if (core_done && run_q != '0) begin
          cyc_d[idx_q] = run_nxt;
          srch_d       = idx_q + 1'b1;
          state_d      = S_PICK;
        end
`ifdef PROG_SEQ_TIMEOUT_EN
        else if (run_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
          cyc_d[idx_q] = CNT_W'(TIMEOUT_CYCLES);
          tmo_d        = 1'b1;
          state_d      = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // busy covers PICK only when a program is still pending, so an empty mask
  // or the final empty search never raises it.
  assign pend_d = any_prog(mask_d, srch_d);

  always_ff @(posedge clk) begin
    if (init) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      srch_q      <= '0;
      mask_q      <= '0;
      hold_q      <= '0;
      for (int i = 0; i < NUM_PROGS; i++) cyc_q[i] <= '0;
      core_init_q <= 1'b1;
      busy_q      <= 1'b0;
      all_done_q  <= 1'b0;
      pc_q        <= PC_W'(prog_pc('0));
`ifdef PROG_SEQ_TIMEOUT_EN
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      srch_q      <= srch_d;
      mask_q      <= mask_d;
      hold_q      <= hold_d;
      for (int i = 0; i < NUM_PROGS; i++) cyc_q[i] <= cyc_d[i];
      core_init_q <= (state_d != S_RUN);
      busy_q      <= (state_d == S_HOLD) || (state_d == S_RUN) ||
                     ((state_d == S_PICK) && pend_d);
      all_done_q  <= (state_d == S_DONE);
      pc_q        <= PC_W'(prog_pc(idx_d));
`ifdef PROG_SEQ_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign core_init     = core_init_q;
  assign core_start_pc = pc_q;
  assign busy          = busy_q;
  assign prog_idx      = idx_q;
  assign all_done      = all_done_q;
  assign cyc_count     = (int'(cyc_sel) < NUM_PROGS) ? cyc_q[cyc_sel] : '0;
`ifdef PROG_SEQ_TIMEOUT_EN
  assign timeout_err   = tmo_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: full sequence, single program, empty
// mask, stale done, init mid-RUN, start during HOLD, and (with
// PROG_SEQ_TIMEOUT_EN) the watchdog with TIMEOUT_CYCLES=100.
module tb_prog_sequencer;
  import prog_seq_pkg::*;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 init, start, core_done;
  logic [NUM_PROGS-1:0] prog_mask;
  logic [IDX_W-1:0]     cyc_sel;
  logic                 core_init, busy, all_done;
  logic [PC_W-1:0]      core_start_pc;
  logic [IDX_W-1:0]     prog_idx;
  logic [CNT_W-1:0]     cyc_count;
`ifdef PROG_SEQ_TIMEOUT_EN
  logic                 timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  prog_sequencer #(
    .PC_W(PC_W), .CNT_W(CNT_W), .INIT_CYCLES(2)
`ifdef PROG_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk), .init(init), .start(start), .prog_mask(prog_mask),
    .core_done(core_done), .core_init(core_init), .core_start_pc(core_start_pc),
    .busy(busy), .prog_idx(prog_idx), .all_done(all_done),
    .cyc_sel(cyc_sel), .cyc_count(cyc_count)
`ifdef PROG_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic read_cnt(input string tag, input logic [IDX_W-1:0] sel,
                          input logic [31:0] exp);
    cyc_sel = sel;
    #1;
    chk(tag, 32'(cyc_count), exp);
  endtask

  task automatic pulse_start(input logic [NUM_PROGS-1:0] m);
    prog_mask = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Called in the PICK cycle that selects this program; returns in the
  // following PICK cycle, after the scoreboard check of the stored count.
  task automatic do_prog(input logic [PC_W-1:0] pc, input logic [IDX_W-1:0] idx,
                         input int done_at);
    chk("pick_busy", 32'(busy), 1);
    chk("pick_core_init", 32'(core_init), 1);
    tick();
    chk("hold1_core_init", 32'(core_init), 1);
    chk("hold1_pc", 32'(core_start_pc), 32'(pc));
    tick();
    chk("hold2_core_init", 32'(core_init), 1);
    chk("hold2_pc", 32'(core_start_pc), 32'(pc));
    tick();
    chk("run1_core_init", 32'(core_init), 0);
    chk("run_prog_idx", 32'(prog_idx), 32'(idx));
    exp_q.push_back(CNT_W'(done_at));
    for (int n = 1; n <= done_at; n++) begin
      core_done = (n == done_at);
      tick();
    end
    core_done = 1'b0;
    chk("post_done_core_init", 32'(core_init), 1);
    read_cnt("cyc_count", idx, 32'(exp_q.pop_front()));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    init = 1'b1; start = 1'b0; core_done = 1'b0; prog_mask = '0; cyc_sel = '0;
    tick(); tick();
    chk("rst_core_init", 32'(core_init), 1);
    chk("rst_pc", 32'(core_start_pc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_prog_idx", 32'(prog_idx), 0);
    chk("rst_all_done", 32'(all_done), 0);
`ifdef PROG_SEQ_TIMEOUT_EN
    chk("rst_timeout", 32'(timeout_err), 0);
`endif
    read_cnt("rst_cnt0", 2'd0, 0);
    read_cnt("rst_cnt2", 2'd2, 0);
    init = 1'b0;
    tick();
    chk("idle_core_init", 32'(core_init), 1);

    // Full sequence
    pulse_start(3'b111);
    do_prog(10'd0, 2'd0, 10);
    do_prog(10'd64, 2'd1, 20);
    do_prog(10'd128, 2'd2, 30);
    chk("full_last_pick_busy", 32'(busy), 0);
    tick();
    chk("full_all_done", 32'(all_done), 1);
    chk("full_core_init", 32'(core_init), 1);
    chk("full_prog_idx", 32'(prog_idx), 2);
    read_cnt("full_cnt0", 2'd0, 10);
    read_cnt("full_cnt1", 2'd1, 20);
    read_cnt("full_cnt2", 2'd2, 30);

    // Single program (also accepted from DONE)
    pulse_start(3'b010);
    chk("single_all_done_drop", 32'(all_done), 0);
    do_prog(10'd64, 2'd1, 5);
    tick();
    chk("single_all_done", 32'(all_done), 1);
    read_cnt("single_cnt0", 2'd0, 0);
    read_cnt("single_cnt2", 2'd2, 0);

    // Empty mask
    pulse_start(3'b000);
    chk("empty_k1_busy", 32'(busy), 0);
    chk("empty_k1_core_init", 32'(core_init), 1);
    chk("empty_k1_all_done", 32'(all_done), 0);
    tick();
    chk("empty_k2_all_done", 32'(all_done), 1);
    chk("empty_k2_busy", 32'(busy), 0);
    chk("empty_k2_core_init", 32'(core_init), 1);

    // Stale done held into RUN cycle 1
    pulse_start(3'b001);
    tick();
    tick();
    core_done = 1'b1;
    tick();
    chk("stale_run1_core_init", 32'(core_init), 0);
    tick();
    chk("stale_run2_core_init", 32'(core_init), 0);
    tick();
    core_done = 1'b0;
    chk("stale_pick_core_init", 32'(core_init), 1);
    read_cnt("stale_cnt0", 2'd0, 2);
    tick();
    chk("stale_all_done", 32'(all_done), 1);

    // init mid-RUN of program 1, start ignored during HOLD
    pulse_start(3'b111);
    do_prog(10'd0, 2'd0, 3);
    tick();
    prog_mask = 3'b000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("hold_start_busy", 32'(busy), 1);
    chk("hold_start_pc", 32'(core_start_pc), 64);
    tick();
    chk("hold_start_run_core_init", 32'(core_init), 0);
    chk("hold_start_run_idx", 32'(prog_idx), 1);
    tick();
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("midrun_core_init", 32'(core_init), 1);
    chk("midrun_busy", 32'(busy), 0);
    chk("midrun_all_done", 32'(all_done), 0);
    chk("midrun_prog_idx", 32'(prog_idx), 0);
    chk("midrun_pc", 32'(core_start_pc), 0);
    read_cnt("midrun_cnt0", 2'd0, 0);
    tick(); tick();
    chk("midrun_idle_core_init", 32'(core_init), 1);
    chk("midrun_idle_busy", 32'(busy), 0);

`ifdef PROG_SEQ_TIMEOUT_EN
    // Watchdog: core_done never raised
    pulse_start(3'b111);
    tick(); tick(); tick();
    chk("wd_run1_core_init", 32'(core_init), 0);
    repeat (99) tick();
    chk("wd_run100_core_init", 32'(core_init), 0);
    chk("wd_run100_timeout", 32'(timeout_err), 0);
    tick();
    chk("wd_timeout", 32'(timeout_err), 1);
    chk("wd_all_done", 32'(all_done), 1);
    chk("wd_core_init", 32'(core_init), 1);
    read_cnt("wd_cnt0", 2'd0, 100);
    repeat (5) tick();
    chk("wd_no_restart_core_init", 32'(core_init), 1);
    chk("wd_prog_idx", 32'(prog_idx), 0);
    read_cnt("wd_cnt1", 2'd1, 0);
    chk("wd_sticky", 32'(timeout_err), 1);
`endif

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
